// File: rtl/img_pkg.sv
// Shared constants and helpers for the image-processing pipeline stages.
package img_pkg;

  localparam int         PIX_W     = 8;
  localparam int         SOBEL_LAT = 4;
  localparam logic [7:0] MAG_SAT   = 8'd255;

  function automatic logic [9:0] abs_diff10(input logic [9:0] a, input logic [9:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sobel_window_3x3.sv
// Builds a 3x3 pixel window from two line buffers and flags windows that lie
// fully inside the image (at least two rows and two columns already seen).
module sobel_window_3x3
  import img_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int ADDR_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vsync,
  input  logic             valid,
  input  logic [PIX_W-1:0] pix,
  output logic [PIX_W-1:0] p11,
  output logic [PIX_W-1:0] p12,
  output logic [PIX_W-1:0] p13,
  output logic [PIX_W-1:0] p21,
  output logic [PIX_W-1:0] p22,
  output logic [PIX_W-1:0] p23,
  output logic [PIX_W-1:0] p31,
  output logic [PIX_W-1:0] p32,
  output logic [PIX_W-1:0] p33,
  output logic             window_ok
);

  localparam logic [ADDR_W:0] HDISP = (ADDR_W+1)'(IMG_HDISP);

  logic [ADDR_W:0]   col;
  logic [1:0]        row;
  logic              vsync_d;
  logic              valid_d;
  logic              vsync_rise;
  logic              end_of_line;
  logic [ADDR_W:0]   col_eff;
  logic [1:0]        row_eff;
  logic              in_range;
  logic [ADDR_W-1:0] addr;
  logic [PIX_W-1:0]  rd0;
  logic [PIX_W-1:0]  rd1;

  logic [PIX_W-1:0] linebuf0 [0:(1<<ADDR_W)-1];
  logic [PIX_W-1:0] linebuf1 [0:(1<<ADDR_W)-1];

  // A vsync rise wins over everything: the coincident pixel is treated as row 0, col 0.
  assign vsync_rise  = vsync & ~vsync_d;
  assign end_of_line = valid_d & ~valid;
  assign col_eff     = vsync_rise ? '0 : col;
  assign row_eff     = vsync_rise ? 2'd0 : row;
  assign in_range    = (col_eff < HDISP);
  assign addr        = col_eff[ADDR_W-1:0];
  assign rd0         = linebuf0[addr];
  assign rd1         = linebuf1[addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col     <= '0;
      row     <= 2'd0;
      vsync_d <= 1'b0;
      valid_d <= 1'b0;
    end else begin
      vsync_d <= vsync;
      valid_d <= valid;
      if (vsync_rise) begin
        row <= 2'd0;
        col <= valid ? (ADDR_W+1)'(1) : '0;
      end else if (end_of_line) begin
        col <= '0;
        row <= (row == 2'd3) ? 2'd3 : row + 2'd1;
      end else if (valid && (col != '1)) begin
        col <= col + (ADDR_W+1)'(1);
      end
    end
  end

  // Buffer 1 holds the previous line, buffer 0 the one before; both shift down on each write.
  always_ff @(posedge clk) begin
    if (valid && in_range) begin
      linebuf1[addr] <= pix;
      linebuf0[addr] <= rd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {p11, p12, p13, p21, p22, p23, p31, p32, p33} <= '0;
      window_ok <= 1'b0;
    end else begin
      if (valid && in_range) begin
        p11 <= p12;
        p12 <= p13;
        p13 <= rd0;
        p21 <= p22;
        p22 <= p23;
        p23 <= rd1;
        p31 <= p32;
        p32 <= p33;
        p33 <= pix;
      end
      window_ok <= valid && in_range && (row_eff >= 2'd2) && (col_eff >= (ADDR_W+1)'(2));
    end
  end

endmodule

// File: rtl/sobel_edge_detector.sv
// Sobel gradient magnitude |Gx|+|Gy| with a per-frame threshold, producing an
// 8-bit saturated magnitude and a binary edge flag four cycles after the input.
module sobel_edge_detector
  import img_pkg::*;
#(
  parameter int         IMG_HDISP   = 640,
  parameter int         ADDR_W      = 10,
  parameter logic [7:0] THR_DEFAULT = 8'd64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pre_frame_vsync,
  input  logic             pre_frame_hsync,
  input  logic             pre_frame_valid,
  input  logic [PIX_W-1:0] pre_img_y,
  input  logic [7:0]       threshold,
  output logic             post_frame_vsync,
  output logic             post_frame_hsync,
  output logic             post_frame_valid,
  output logic [7:0]       post_img_mag,
  output logic             post_img_bit
);

  logic [PIX_W-1:0]     p11, p12, p13, p21, p22, p23, p31, p32, p33;
  logic                 window_ok;
  logic [SOBEL_LAT-1:0] vs_dly, hs_dly, va_dly;
  logic [7:0]           thr_r;
  logic                 vsync_rise;
  logic [9:0]           gx_pos, gx_neg, gy_pos, gy_neg;
  logic [9:0]           gx_abs, gy_abs;
  logic                 ok_s2, ok_s3;
  logic [10:0]          mag;
  logic [7:0]           mag_sat;
  logic                 gate;

  sobel_window_3x3 #(
    .IMG_HDISP (IMG_HDISP),
    .ADDR_W    (ADDR_W)
  ) u_window (
    .clk       (clk),
    .rst_n     (rst_n),
    .vsync     (pre_frame_vsync),
    .valid     (pre_frame_valid),
    .pix       (pre_img_y),
    .p11       (p11),
    .p12       (p12),
    .p13       (p13),
    .p21       (p21),
    .p22       (p22),
    .p23       (p23),
    .p31       (p31),
    .p32       (p32),
    .p33       (p33),
    .window_ok (window_ok)
  );

  assign vsync_rise = pre_frame_vsync & ~vs_dly[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_dly <= '0;
      hs_dly <= '0;
      va_dly <= '0;
      thr_r  <= THR_DEFAULT;
    end else begin
      vs_dly <= {vs_dly[SOBEL_LAT-2:0], pre_frame_vsync};
      hs_dly <= {hs_dly[SOBEL_LAT-2:0], pre_frame_hsync};
      va_dly <= {va_dly[SOBEL_LAT-2:0], pre_frame_valid};
      if (vsync_rise) thr_r <= threshold;
    end
  end

  assign mag     = {1'b0, gx_abs} + {1'b0, gy_abs};
  assign mag_sat = (mag > 11'd255) ? MAG_SAT : mag[7:0];
  assign gate    = ok_s3 & va_dly[SOBEL_LAT-2];

  // Stage 2 forms the weighted column/row sums, stage 3 their absolute differences.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_pos       <= '0;
      gx_neg       <= '0;
      gy_pos       <= '0;
      gy_neg       <= '0;
      gx_abs       <= '0;
      gy_abs       <= '0;
      ok_s2        <= 1'b0;
      ok_s3        <= 1'b0;
      post_img_mag <= '0;
      post_img_bit <= 1'b0;
    end else begin
      gx_pos       <= {2'b00, p13} + {1'b0, p23, 1'b0} + {2'b00, p33};
      gx_neg       <= {2'b00, p11} + {1'b0, p21, 1'b0} + {2'b00, p31};
      gy_pos       <= {2'b00, p31} + {1'b0, p32, 1'b0} + {2'b00, p33};
      gy_neg       <= {2'b00, p11} + {1'b0, p12, 1'b0} + {2'b00, p13};
      ok_s2        <= window_ok;
      gx_abs       <= abs_diff10(gx_pos, gx_neg);
      gy_abs       <= abs_diff10(gy_pos, gy_neg);
      ok_s3        <= ok_s2;
      post_img_mag <= gate ? mag_sat : 8'd0;
      post_img_bit <= gate && (mag_sat > thr_r);
    end
  end

  assign post_frame_vsync = vs_dly[SOBEL_LAT-1];
  assign post_frame_hsync = hs_dly[SOBEL_LAT-1];
  assign post_frame_valid = va_dly[SOBEL_LAT-1];

endmodule

// File: tb/tb_sobel_edge_detector.sv
// Directed-frame bench for sobel_edge_detector on an 8x4 geometry, checked
// every cycle against a behavioural Sobel model and pinned by literal values.
module tb_sobel_edge_detector;

  localparam int W       = 8;
  localparam int H       = 4;
  localparam int THR_DEF = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       vsync = 1'b0;
  logic       hsync = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] pix = 8'd0;
  logic [7:0] threshold = 8'd64;
  logic       post_frame_vsync;
  logic       post_frame_hsync;
  logic       post_frame_valid;
  logic [7:0] post_img_mag;
  logic       post_img_bit;

  sobel_edge_detector #(
    .IMG_HDISP   (W),
    .ADDR_W      (3),
    .THR_DEFAULT (8'd64)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pre_frame_vsync  (vsync),
    .pre_frame_hsync  (hsync),
    .pre_frame_valid  (valid),
    .pre_img_y        (pix),
    .threshold        (threshold),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_hsync (post_frame_hsync),
    .post_frame_valid (post_frame_valid),
    .post_img_mag     (post_img_mag),
    .post_img_bit     (post_img_bit)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int expMagQ[$];
  int expBitQ[$];
  int obsMag [0:1023];
  int obsBit [0:1023];
  int obsCount = 0;
  int img  [0:H-1][0:W-1];
  int hist [0:2][0:W-1];
  int modelRow = 0;
  int modelThr = THR_DEF;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkLit(input string name, input int idx, input int eMag, input int eBit);
    checkOutput({name, "_mag"}, obsMag[idx], eMag);
    checkOutput({name, "_bit"}, obsBit[idx], eBit);
  endtask

  // Reference window: hist[0] is two lines back, hist[2] the line being driven.
  function automatic int sobelRef(input int c);
    int gx, gy, m;
    gx = (hist[0][c] + 2*hist[1][c] + hist[2][c])
       - (hist[0][c-2] + 2*hist[1][c-2] + hist[2][c-2]);
    gy = (hist[2][c-2] + 2*hist[2][c-1] + hist[2][c])
       - (hist[0][c-2] + 2*hist[0][c-1] + hist[0][c]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    m = gx + gy;
    return (m > 255) ? 255 : m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveVsync(input int thr);
    threshold = 8'(thr);
    vsync     = 1'b1;
    modelRow  = 0;
    modelThr  = thr;
    tick();
    tick();
    vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic driveLine(input int r, input int ncols);
    for (int c = 0; c < ncols; c++) begin
      int m;
      hist[2][c] = img[r][c];
      m = (modelRow >= 2 && c >= 2) ? sobelRef(c) : 0;
      expMagQ.push_back(m);
      expBitQ.push_back((m > modelThr) ? 1 : 0);
      valid = 1'b1;
      hsync = 1'b1;
      pix   = 8'(img[r][c]);
      tick();
    end
    if (ncols == W) begin
      valid = 1'b0;
      hsync = 1'b0;
      pix   = 8'd0;
      for (int c = 0; c < W; c++) begin
        hist[0][c] = hist[1][c];
        hist[1][c] = hist[2][c];
      end
      if (modelRow < 3) modelRow++;
      repeat (4) tick();
    end
  endtask

  task automatic applyStimulus(input int thrStart, input int thrMid, output int base);
    base = obsCount;
    driveVsync(thrStart);
    for (int r = 0; r < H; r++) begin
      if (r == 2) threshold = 8'(thrMid);
      driveLine(r, W);
    end
    repeat (6) tick();
  endtask

  // Single compare process: syncs against a 4-deep input history, pixels against the model queue.
  task automatic monitor();
    logic [3:0] vsH, hsH, vaH;
    int em, eb;
    vsH = '0;
    hsH = '0;
    vaH = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        vsH = '0;
        hsH = '0;
        vaH = '0;
        checkOutput("rst_valid", int'(post_frame_valid), 0);
        checkOutput("rst_mag", int'(post_img_mag), 0);
        checkOutput("rst_bit", int'(post_img_bit), 0);
      end else begin
        checkOutput("vsync_delay", int'(post_frame_vsync), int'(vsH[3]));
        checkOutput("hsync_delay", int'(post_frame_hsync), int'(hsH[3]));
        checkOutput("valid_delay", int'(post_frame_valid), int'(vaH[3]));
        if (post_frame_valid) begin
          if (expMagQ.size() == 0) begin
            checkOutput("unexpected_valid", 1, 0);
          end else begin
            em = expMagQ.pop_front();
            eb = expBitQ.pop_front();
            checkOutput("pix_mag", int'(post_img_mag), em);
            checkOutput("pix_bit", int'(post_img_bit), eb);
          end
          if (obsCount < 1024) begin
            obsMag[obsCount] = int'(post_img_mag);
            obsBit[obsCount] = int'(post_img_bit);
          end
          obsCount++;
        end else begin
          checkOutput("idle_mag", int'(post_img_mag), 0);
          checkOutput("idle_bit", int'(post_img_bit), 0);
        end
        vsH = {vsH[2:0], vsync};
        hsH = {hsH[2:0], hsync};
        vaH = {vaH[2:0], valid};
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    fork
      monitor();
    join_none

    #1 rst_n = 1'b0;
    repeat (3) tick();
    checkOutput("reset_mag", int'(post_img_mag), 0);
    checkOutput("reset_bit", int'(post_img_bit), 0);
    checkOutput("reset_valid", int'(post_frame_valid), 0);
    checkOutput("reset_vsync", int'(post_frame_vsync), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Flat frame: no gradient anywhere, every pixel passes through
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 100;
    applyStimulus(64, 64, base);
    checkOutput("flat_valid_count", obsCount - base, 32);
    checkLit("flat_r2c4", base + 2*W + 4, 0, 0);
    checkLit("flat_r3c7", base + 3*W + 7, 0, 0);

    // Vertical step 0 -> 200 between columns 3 and 4
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c < 4) ? 0 : 200;
    applyStimulus(64, 64, base);
    checkLit("vstep_r2c4", base + 2*W + 4, 255, 1);
    checkLit("vstep_r2c5", base + 2*W + 5, 255, 1);
    checkLit("vstep_r3c4", base + 3*W + 4, 255, 1);
    checkLit("vstep_r2c3", base + 2*W + 3, 0, 0);
    checkLit("vstep_r2c6", base + 2*W + 6, 0, 0);
    checkLit("vstep_r1c4", base + 1*W + 4, 0, 0);
    checkLit("vstep_r2c1", base + 2*W + 1, 0, 0);

    // Horizontal step 50 -> 60 between rows 1 and 2
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (r < 2) ? 50 : 60;
    applyStimulus(64, 64, base);
    checkLit("hstep64_r2c2", base + 2*W + 2, 40, 0);
    checkLit("hstep64_r3c7", base + 3*W + 7, 40, 0);

    applyStimulus(30, 64, base);
    checkLit("hstep30_r2c2", base + 2*W + 2, 40, 1);
    checkLit("hstep30_mid_r3c5", base + 3*W + 5, 40, 1);
    checkLit("hstep30_r0c5", base + 0*W + 5, 0, 0);
    checkLit("hstep30_r3c0", base + 3*W + 0, 0, 0);

    applyStimulus(64, 64, base);
    checkLit("hstep_next_r3c5", base + 3*W + 5, 40, 0);

    // Reset in the middle of row 2 while edge pixels are leaving the pipeline
    driveVsync(30);
    driveLine(0, W);
    driveLine(1, W);
    driveLine(2, 7);
    checkOutput("pre_rst_mag", int'(post_img_mag), 40);
    checkOutput("pre_rst_bit", int'(post_img_bit), 1);
    checkOutput("pre_rst_valid", int'(post_frame_valid), 1);
    rst_n = 1'b0;
    valid = 1'b0;
    hsync = 1'b0;
    pix   = 8'd0;
    #1;
    checkOutput("rst_async_mag", int'(post_img_mag), 0);
    checkOutput("rst_async_bit", int'(post_img_bit), 0);
    checkOutput("rst_async_valid", int'(post_frame_valid), 0);
    checkOutput("rst_async_hsync", int'(post_frame_hsync), 0);
    expMagQ.delete();
    expBitQ.delete();
    modelRow = 0;
    modelThr = THR_DEF;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // No vsync after release: row restarts at 0 and the default threshold applies
    base = obsCount;
    for (int c = 0; c < W; c++) begin
      img[0][c] = 200;
      img[1][c] = 200;
      img[2][c] = 190;
    end
    driveLine(0, W);
    driveLine(1, W);
    driveLine(2, W);
    repeat (6) tick();
    checkLit("post_rst_l0c4", base + 0*W + 4, 0, 0);
    checkLit("post_rst_l1c4", base + 1*W + 4, 0, 0);
    checkLit("post_rst_l2c2", base + 2*W + 2, 40, 0);
    checkLit("post_rst_l2c6", base + 2*W + 6, 40, 0);
    checkOutput("queue_drained", expMagQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
